// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand/result bundle between an ALU and its datapath
//
// Purpose: groups the ALU operands, operation select, combinational result
//          and flags, and the registered result/flags into one interface.
// Signals:
//   a, b     operands (srca, srcb), WIDTH bits
//   f        3-bit operation select (alucontrol)
//   y        combinational result (aluresult)
//   zero     1 when y is all zeros
//   cout     carry-out of add/sub, 0 otherwise
//   ovf      signed overflow of add/sub, 0 otherwise
//   y_r      registered copy of y
//   flags_r  registered {cout, ovf, zero}
// Modports: master drives operands and observes results; slave is the ALU.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       f;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] y_r;
    logic [2:0]       flags_r;

    modport master (
        output a, b, f,
        input  y, zero, cout, ovf, y_r, flags_r
    );

    modport slave (
        input  a, b, f,
        output y, zero, cout, ovf, y_r, flags_r
    );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with registered result and flags
//
// Purpose: AND/OR/ADD/SUB/SLT on WIDTH-bit operands with zero-latency result
//          and flags, plus a registered copy of result and flags.
// Ports:
//   clk    rising-edge clock for the result/flag registers
//   reset  synchronous active-high; clears y_r to 0 and flags_r to 3'b001
//   bus    alu_if.slave: a, b, f in; y, zero, cout, ovf, y_r, flags_r out
// Configuration:
//   ALU_EXT_OPS_EN  when defined, f=011 xor, f=100 nor, f=101 sltu;
//                   otherwise those codes give y = 0.
module alu #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             add_ovf;
    logic             sub_ovf;
    logic             slt_lt;

    logic [WIDTH-1:0] y_d;
    logic             cout_d;
    logic             ovf_d;
    logic             zero_d;

    logic [WIDTH-1:0] y_q;
    logic [2:0]       flags_q;
    logic [2:0]       flags_d;

    // One extra bit on each sum holds the carry-out of the MSB.
    assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};
    assign sub_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};

    assign add_ovf = (bus.a[MSB] == bus.b[MSB]) && (add_sum[MSB] != bus.a[MSB]);
    assign sub_ovf = (bus.a[MSB] != bus.b[MSB]) && (sub_sum[MSB] != bus.a[MSB]);

    // Correcting the sign of the difference by overflow keeps slt right at
    // the extremes (e.g. most-negative minus a positive value).
    assign slt_lt  = sub_sum[MSB] ^ sub_ovf;

    always_comb begin
        y_d    = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (bus.f)
            3'b000: y_d = bus.a & bus.b;
            3'b001: y_d = bus.a | bus.b;
            3'b010: begin
                y_d    = add_sum[MSB:0];
                cout_d = add_sum[WIDTH];
                ovf_d  = add_ovf;
            end
            3'b110: begin
                y_d    = sub_sum[MSB:0];
                cout_d = sub_sum[WIDTH];
                ovf_d  = sub_ovf;
            end
            3'b111: y_d = {{(WIDTH-1){1'b0}}, slt_lt};
`ifdef ALU_EXT_OPS_EN
            3'b011: y_d = bus.a ^ bus.b;
            3'b100: y_d = ~(bus.a | bus.b);
            // Unsigned less-than is a borrow, i.e. no carry out of a + ~b + 1.
            3'b101: y_d = {{(WIDTH-1){1'b0}}, ~sub_sum[WIDTH]};
`else
            3'b011: y_d = '0;
            3'b100: y_d = '0;
            3'b101: y_d = '0;
`endif
            default: y_d = '0;
        endcase
    end

    assign zero_d  = (y_d == '0);
    assign flags_d = {cout_d, ovf_d, zero_d};

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q     <= '0;
            flags_q <= 3'b001;
        end else begin
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

    assign bus.y       = y_d;
    assign bus.zero    = zero_d;
    assign bus.cout    = cout_d;
    assign bus.ovf     = ovf_d;
    assign bus.y_r     = y_q;
    assign bus.flags_r = flags_q;
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu (directed table + random vs model)
module tb_alu;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic [31:0] y;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                input logic [31:0] y, input logic c, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.y = y; v.cout = c; v.ovf = o; v.zero = (y == 32'd0);
        return v;
    endfunction

    // Reference model: exact integer arithmetic, overflow = the true result
    // does not fit in the signed 32-bit value that was produced.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                  output logic [31:0] y, output logic c, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        y = 32'd0; c = 1'b0; o = 1'b0;
        case (f)
            3'd0: y = a & b;
            3'd1: y = a | b;
            3'd2: begin
                r = sa + sb;
                y = a + b;
                c = (longint'(a) + longint'(b)) > 64'sh0_FFFF_FFFF;
                o = (r != longint'($signed(y)));
            end
            3'd6: begin
                r = sa - sb;
                y = a - b;
                c = (a >= b);
                o = (r != longint'($signed(y)));
            end
            3'd7: y = (sa < sb) ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
            3'd3: y = a ^ b;
            3'd4: y = ~(a | b);
            3'd5: y = (a < b) ? 32'd1 : 32'd0;
`endif
            default: y = 32'd0;
        endcase
    endfunction

    // Drives one operation just after a rising edge, checks the combinational
    // outputs, then checks the registered copy after the next edge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [31:0] ey, input logic ec,
                          input logic eo, input logic do_reg);
        logic ez;
        ez = (ey == 32'd0);
        bus.a = a; bus.b = b; bus.f = f;
        #1;
        check({tag, "_y"},    bus.y,    ey);
        check({tag, "_cout"}, bus.cout, ec);
        check({tag, "_ovf"},  bus.ovf,  eo);
        check({tag, "_zero"}, bus.zero, ez);
        @(posedge clk);
        #1;
        if (do_reg) begin
            check({tag, "_y_r"},     bus.y_r,     ey);
            check({tag, "_flags_r"}, bus.flags_r, {ec, eo, ez});
        end
    endtask

    initial begin
        logic [31:0] my;
        logic        mc;
        logic        mo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        logic [31:0] corner [5];

        vecs.push_back(mk(32'h7FFF_FFFF, 32'h1,         3'b010, 32'h8000_0000, 1'b0, 1'b1));
        vecs.push_back(mk(32'h5,         32'h5,         3'b110, 32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(32'h0,         32'h1,         3'b110, 32'hFFFF_FFFF, 1'b0, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h1,         3'b111, 32'h1,         1'b0, 1'b0));
        vecs.push_back(mk(32'h1,         32'h8000_0000, 3'b111, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b000, 32'h00F0_00F0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h1,         3'b010, 32'h0,         1'b1, 1'b0));
        vecs.push_back(mk(32'h8000_0000, 32'h1,         3'b110, 32'h7FFF_FFFF, 1'b1, 1'b1));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'h1,         3'b101, 32'h0,         1'b0, 1'b0));
`ifdef ALU_EXT_OPS_EN
        vecs.push_back(mk(32'h1,         32'hFFFF_FFFF, 3'b101, 32'h1,         1'b0, 1'b0));
        vecs.push_back(mk(32'h1234_5678, 32'h1234_5678, 3'b011, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(32'h0F0F_0000, 32'h00F0_0000, 3'b100, 32'hF000_FFFF, 1'b0, 1'b0));
`else
        vecs.push_back(mk(32'h1,         32'hFFFF_FFFF, 3'b101, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(32'h1234_5678, 32'h8765_4321, 3'b011, 32'h0,         1'b0, 1'b0));
        vecs.push_back(mk(32'h0F0F_0000, 32'h00F0_0000, 3'b100, 32'h0,         1'b0, 1'b0));
`endif

        // Reset state
        reset = 1'b1;
        bus.a = 32'h3; bus.b = 32'h4; bus.f = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        check("rst_y_r",     bus.y_r,     32'h0);
        check("rst_flags_r", bus.flags_r, 3'b001);
        check("rst_y_comb",  bus.y,       32'h7);
        reset = 1'b0;

        // Directed table
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].f,
                   vecs[i].y, vecs[i].cout, vecs[i].ovf, 1'b1);

        // Mid-sequence reset: clears registers for one edge, comb path unaffected
        run_op("pre_rst", 32'h10, 32'h20, 3'b010, 32'h30, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        bus.a = 32'hF0F0_F0F0; bus.b = 32'h0FF0_0FF0; bus.f = 3'b001;
        #1;
        check("midrst_y_comb_before", bus.y, 32'hFFF0_FFF0);
        @(posedge clk);
        #1;
        check("midrst_y_r",     bus.y_r,     32'h0);
        check("midrst_flags_r", bus.flags_r, 3'b001);
        check("midrst_y_comb",  bus.y,       32'hFFF0_FFF0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_y_r",     bus.y_r,     32'hFFF0_FFF0);
        check("post_rst_flags_r", bus.flags_r, 3'b000);

        // Randomized against the model, operands biased toward corners
        corner[0] = 32'h0;
        corner[1] = 32'h1;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'hFFFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 9) == 0) rb = ra;
            rf = 3'($urandom_range(0, 7));
            model(ra, rb, rf, my, mc, mo);
            run_op($sformatf("rnd%0d_f%0d", i, rf), ra, rb, rf, my, mc, mo, (i % 4) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
